// File: rtl/instruction_memory_sync.sv
// instruction_memory_sync: synchronous-read instruction memory with stall/flush, error flagging and a load port
module instruction_memory_sync #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W = 32,
  parameter logic [31:0] BASE_ADDR = 32'h00000000,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_en,
  input  logic [31:0]          fetch_addr,
  input  logic                 stall,
  input  logic                 flush,
  output logic [DATA_W-1:0]    instr,
  output logic [31:0]          instr_pc,
  output logic                 instr_valid,
  output logic                 addr_err,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_idx,
  input  logic [DATA_W-1:0]    load_data
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB = $clog2(BYTES);
  localparam int DEPTH = 2 ** ADDR_BITS;
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};
  logic [31:0] off;
  logic [ADDR_BITS-1:0] idx;
  logic ok;
  logic [DATA_W-1:0] rd;
  // modular offset: addresses below BASE_ADDR wrap high and fall out of range
  always_comb begin
    off = fetch_addr - BASE_ADDR;
    idx = off[LB +: ADDR_BITS];
    ok = ((fetch_addr & 32'(BYTES - 1)) == 32'd0) && ((off >> (ADDR_BITS + LB)) == 32'd0);
    rd = (load_en && load_idx == idx) ? load_data : mem[idx];
  end
  always_ff @(posedge clk)
    if (!reset && load_en) mem[load_idx] <= load_data;
  always_ff @(posedge clk)
    if (reset) begin
      instr <= NOP_WORD;
      instr_pc <= '0;
      instr_valid <= 1'b0;
      addr_err <= 1'b0;
    end else if (flush) begin
      instr <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_err <= 1'b0;
    end else if (!stall) begin
      instr <= (fetch_en && ok) ? rd : NOP_WORD;
      instr_valid <= fetch_en;
      addr_err <= fetch_en && !ok;
      if (fetch_en) instr_pc <= fetch_addr;
    end
endmodule

// File: tb/tb_instruction_memory_sync.sv
// tb_instruction_memory_sync: directed scoreboard bench, base-0 and offset-base instances
module tb_instruction_memory_sync;
  typedef struct {
    logic chk;
    logic [31:0] instr;
    logic [31:0] pc;
    logic v;
    logic e;
  } exp_t;
  typedef struct {
    exp_t a;
    exp_t b;
    int n;
  } ent_t;
  logic clk = 0, reset, fetch_en, fetch_en1, stall, flush, load_en;
  logic [31:0] fetch_addr, fetch_addr1, load_data;
  logic [7:0] load_idx;
  logic [31:0] instr0, instr1, pc0, pc1;
  logic v0, v1, e0, e1;
  ent_t q[$];
  int step = 0, compared = 0, mismatched = 0;
  exp_t none = '{chk: 1'b0, instr: '0, pc: '0, v: 1'b0, e: 1'b0};
  always #5 clk = ~clk;
  instruction_memory_sync dut0 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .stall(stall), .flush(flush), .instr(instr0), .instr_pc(pc0),
    .instr_valid(v0), .addr_err(e0), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data)
  );
  instruction_memory_sync #(.BASE_ADDR(32'h00400000)) dut1 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en1), .fetch_addr(fetch_addr1),
    .stall(stall), .flush(flush), .instr(instr1), .instr_pc(pc1),
    .instr_valid(v1), .addr_err(e1), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data)
  );
  function automatic exp_t ex(input logic [31:0] i, input logic [31:0] p, input logic v, input logic e);
    ex = '{chk: 1'b1, instr: i, pc: p, v: v, e: e};
  endfunction
  task automatic chk(input int n, input int d, input exp_t x, input logic [31:0] i, input logic [31:0] p, input logic v, input logic e);
    if (x.chk) begin
      compared++;
      if (i !== x.instr || p !== x.pc || v !== x.v || e !== x.e) begin
        mismatched++;
        $display("FAIL step%0d dut%0d: got instr=%h pc=%h valid=%b err=%b, want instr=%h pc=%h valid=%b err=%b",
                 n, d, i, p, v, e, x.instr, x.pc, x.v, x.e);
      end
    end
  endtask
  // the response to the edge after a stimulus is visible at the following falling edge
  always @(negedge clk)
    if (q.size() > 0) begin : mon
      ent_t t;
      t = q.pop_front();
      chk(t.n, 0, t.a, instr0, pc0, v0, e0);
      chk(t.n, 1, t.b, instr1, pc1, v1, e1);
    end
  task automatic tick(input exp_t a, input exp_t b);
    q.push_back('{a: a, b: b, n: step});
    step++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    reset = 0; fetch_en = 0; fetch_addr = 0; fetch_en1 = 0; fetch_addr1 = 0;
    stall = 0; flush = 0; load_en = 0; load_idx = 0; load_data = 0;
  endtask
  task automatic ld(input logic [7:0] i, input logic [31:0] d);
    load_en = 1; load_idx = i; load_data = d;
  endtask
  task automatic f(input logic [31:0] a);
    fetch_en = 1; fetch_addr = a;
  endtask
  initial begin
    idle();
    reset = 1; ld(7, 32'hdeadbeef);
    tick(ex(0, 0, 0, 0), ex(0, 0, 0, 0));
    idle(); ld(0, 32'h20040000); tick(ex(0, 0, 0, 0), none);
    ld(1, 32'h20050003); tick(ex(0, 0, 0, 0), none);
    ld(2, 32'hac850000); tick(ex(0, 0, 0, 0), none);
    idle(); reset = 1; tick(ex(0, 0, 0, 0), ex(0, 0, 0, 0));
    idle(); f(0); tick(ex(32'h20040000, 0, 1, 0), none);
    f(4); tick(ex(32'h20050003, 4, 1, 0), none);
    f(8); tick(ex(32'hac850000, 8, 1, 0), none);
    idle(); tick(ex(0, 8, 0, 0), none);
    f(4); tick(ex(32'h20050003, 4, 1, 0), none);
    f(8); stall = 1;
    repeat (3) tick(ex(32'h20050003, 4, 1, 0), none);
    flush = 1; tick(ex(0, 4, 0, 0), none);
    stall = 0; tick(ex(0, 4, 0, 0), none);
    idle(); f(6); tick(ex(0, 6, 1, 1), none);
    stall = 1; fetch_en = 0; tick(ex(0, 6, 1, 1), none);
    idle(); f(32'h400); tick(ex(0, 32'h400, 1, 1), none);
    f(32'h3fc); tick(ex(0, 32'h3fc, 1, 0), none);
    f(32'h1c); tick(ex(0, 32'h1c, 1, 0), none);
    ld(5, 32'h0c00000c); f(32'h14); tick(ex(32'h0c00000c, 32'h14, 1, 0), none);
    idle(); f(32'h14); tick(ex(32'h0c00000c, 32'h14, 1, 0), none);
    f(4); tick(ex(32'h20050003, 4, 1, 0), none);
    idle(); stall = 1; ld(1, 32'h11111111); tick(ex(32'h20050003, 4, 1, 0), none);
    idle(); f(4); tick(ex(32'h11111111, 4, 1, 0), none);
    idle(); fetch_en1 = 1; fetch_addr1 = 32'h00400008;
    tick(ex(0, 4, 0, 0), ex(32'hac850000, 32'h00400008, 1, 0));
    fetch_addr1 = 32'h003ffffc; tick(none, ex(0, 32'h003ffffc, 1, 1));
    fetch_addr1 = 32'h00400400; tick(none, ex(0, 32'h00400400, 1, 1));
    fetch_addr1 = 32'h004003fc; tick(none, ex(0, 32'h004003fc, 1, 0));
    idle(); f(8); tick(ex(32'hac850000, 8, 1, 0), none);
    stall = 1; reset = 1; ld(2, 32'hffffffff); tick(ex(0, 0, 0, 0), ex(0, 0, 0, 0));
    idle(); f(8); tick(ex(32'hac850000, 8, 1, 0), none);
    f(0); tick(ex(32'h20040000, 0, 1, 0), none);
    idle();
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instruction_memory_sync.md
Name: instruction_memory_sync

Overview:
Parametrised, synchronous-read instruction memory for the pipelined MIPS core, replacing the combinational case-ROM in the IF stage. One registered read port feeds the IF/ID boundary, with stall hold, flush-to-NOP and alignment/range error flagging. A word-wide load port lets the bench or a boot loader write the program at run time.

Parameters:
ADDR_BITS, 8, log2 of depth in words; depth = 2^ADDR_BITS
DATA_W, 32, instruction word width
BASE_ADDR, 32'h00000000, byte address of word 0; must be aligned to DATA_W/8
NOP_WORD, 32'h00000000, value driven when no valid instruction is present

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous reset, active high
fetch_en  in  1  start a fetch at fetch_addr this cycle
fetch_addr  in  32  byte address (PC)
stall  in  1  hold all fetch outputs; no new read
flush  in  1  discard in-flight or held instruction
instr  out  DATA_W  fetched instruction (registered)
instr_pc  out  32  byte address that produced instr
instr_valid  out  1  instr/instr_pc are meaningful
addr_err  out  1  fetch was misaligned or out of range
load_en  in  1  write load_data at word index load_idx
load_idx  in  ADDR_BITS  word index for load
load_data  in  DATA_W  word to write

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, with ports named clk and reset.
- Reset values: instr = NOP_WORD, instr_pc = 0, instr_valid = 0, addr_err = 0. Memory contents are not cleared by reset. Simulation initial contents are all NOP_WORD.
- Word index = (fetch_addr - BASE_ADDR) >> log2(DATA_W/8), using 32-bit modular subtraction.
- In range: BASE_ADDR <= fetch_addr < BASE_ADDR + 2^ADDR_BITS*(DATA_W/8).
- Aligned: fetch_addr low log2(DATA_W/8) bits are zero.
- Latency: 1 cycle. A fetch accepted at edge N presents instr, instr_pc and instr_valid after edge N.
- Per-edge priority: reset > flush > stall > fetch_en > idle.
  - flush: instr = NOP_WORD, instr_valid = 0, addr_err = 0. instr_pc is unchanged. Flush overrides a simultaneous stall or fetch.
  - stall (no flush): every output holds its value. fetch_en is ignored, so the requester must keep fetch_addr stable and re-present it.
  - fetch_en with good address: instr = mem[idx], instr_pc = fetch_addr, instr_valid = 1, addr_err = 0.
  - fetch_en with misaligned or out-of-range address: instr = NOP_WORD, instr_pc = fetch_addr, instr_valid = 1, addr_err = 1. Memory is not read.
  - idle (fetch_en = 0): instr = NOP_WORD, instr_valid = 0, addr_err = 0.
- Load port:
  - Write occurs at the edge whenever load_en = 1, regardless of stall or flush, but not during reset.
  - Write-before-read bypass: if load_en and a fetch hit the same index at the same edge, instr returns load_data.
  - A word already in instr is not updated by a later load.
- No write-back from the fetch path; the memory is single-writer.
- Wrap-around: there is no index wrap. Any address at or beyond the top is out of range and raises addr_err.
- Reset mid-stall or mid-load: reset wins and the load is dropped that cycle.

Test Plan:
- Load & fetch: load idx 0..2 = 20040000, 20050003, ac850000. Reset, then fetch 0x0, 0x4, 0x8 back-to-back -> instr follows 1 cycle later in order, instr_pc = 0x0/0x4/0x8, instr_valid = 1, addr_err = 0.
- Stall/flush: fetch 0x4; stall 3 cycles while fetch_addr = 0x8 -> instr stays 20050003 with valid held. Assert stall+flush together -> next cycle instr = 0, instr_valid = 0.
- Errors:
  - Fetch 0x6 -> addr_err = 1, instr = 0, instr_valid = 1, instr_pc = 0x6.
  - Fetch 0x400 (ADDR_BITS = 8) -> addr_err = 1.
  - Fetch 0x3FC -> addr_err = 0.
- Bypass: same edge, load idx 5 = 0c00000c and fetch 0x14 -> instr = 0c00000c.
- BASE_ADDR = 32'h00400000:
  - Fetch 0x00400008 -> returns word 2.
  - Fetch 0x003FFFFC -> addr_err = 1 (modular subtraction must not alias).
- Reset: assert reset during stall with instr_valid = 1 -> all outputs return to reset values the next cycle; previously loaded words still read back correctly afterwards.
